// File: rtl/fp_to_fixed_pkg.sv
// Shared constants and state encoding for the float to signed Q2.16 converter.
package fp_to_fixed_pkg;

  localparam int unsigned EXP_BIAS   = 127;
  localparam int unsigned FRAC_BITS  = 16;
  localparam int unsigned INT_BITS   = 2;
  localparam int unsigned SHIFT_BASE = 134;
  localparam int unsigned EXP_MIN    = 111;
  localparam int unsigned EXP_MAX    = 127;

  localparam logic [17:0] SAT_POS = 18'h1FFFF;
  localparam logic [17:0] SAT_NEG = 18'h20000;

  typedef enum logic [2:0] {
    StIdle,
    StClassify,
    StShift,
    StNegate,
    StDone
  } state_e;

endpackage

// File: rtl/fp_classify.sv
// Combinational decode of an IEEE-754 single into the special-case classes and
// the right-shift amount that aligns the 24-bit significand to Q2.16.
module fp_classify
  import fp_to_fixed_pkg::*;
(
  input  logic [31:0] fp,
  output logic        is_nan,
  output logic        is_inf,
  output logic        is_zero,
  output logic        is_denorm,
  output logic        too_small,
  output logic        too_big,
  output logic        is_neg_two,
  output logic [4:0]  sh
);

  logic [7:0]  exp_f;
  logic        mant_nz;

  assign exp_f   = fp[30:23];
  assign mant_nz = |fp[22:0];

  assign is_nan     = (exp_f == 8'hFF) && mant_nz;
  assign is_inf     = (exp_f == 8'hFF) && !mant_nz;
  assign is_zero    = (exp_f == 8'h00) && !mant_nz;
  assign is_denorm  = (exp_f == 8'h00) && mant_nz;
  assign too_small  = (exp_f != 8'h00) && (exp_f < 8'(EXP_MIN));
  assign too_big    = (exp_f > 8'(EXP_MAX)) && (exp_f != 8'hFF);
  // -2.0 is the one out-of-range magnitude that Q2.16 represents exactly.
  assign is_neg_two = (fp == 32'hC000_0000);

  // Only meaningful in the in-range window, where it spans 7..23.
  assign sh = 5'(8'(SHIFT_BASE) - exp_f);

endmodule

// File: rtl/fp_to_fixed_seq.sv
// Multi-cycle IEEE-754 single to signed Q2.16 converter with valid/ready on both
// sides; the alignment shift is done as five conditional power-of-two steps.
module fp_to_fixed_seq
  import fp_to_fixed_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] fixed_out,
  output logic        ovf,
  output logic        unf,
  output logic        nan
);

  state_e      state_q, state_d;
  logic [31:0] fp_q;
  logic [23:0] mag_q, mag_shift;
  logic [4:0]  sh_q;
  logic [2:0]  k_q;
  logic [17:0] mag_ext;

  logic is_nan, is_inf, is_zero, is_denorm, too_small, too_big, is_neg_two;
  logic [4:0] sh;
  logic special;

  fp_classify u_classify (
    .fp         (fp_q),
    .is_nan     (is_nan),
    .is_inf     (is_inf),
    .is_zero    (is_zero),
    .is_denorm  (is_denorm),
    .too_small  (too_small),
    .too_big    (too_big),
    .is_neg_two (is_neg_two),
    .sh         (sh)
  );

  assign special = is_nan | is_inf | is_zero | is_denorm | too_small | too_big | is_neg_two;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (in_valid) state_d = StClassify;
      StClassify: state_d = special ? StDone : StShift;
      StShift:    if (k_q == 3'd0) state_d = StNegate;
      StNegate:   state_d = StDone;
      StDone:     if (out_ready) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  // Step k shifts by 2^k when bit k of the shift amount is set (16, 8, 4, 2, 1).
  always_comb begin
    mag_shift = mag_q;
    case (k_q)
      3'd4:    if (sh_q[4]) mag_shift = mag_q >> 16;
      3'd3:    if (sh_q[3]) mag_shift = mag_q >> 8;
      3'd2:    if (sh_q[2]) mag_shift = mag_q >> 4;
      3'd1:    if (sh_q[1]) mag_shift = mag_q >> 2;
      3'd0:    if (sh_q[0]) mag_shift = mag_q >> 1;
      default: mag_shift = mag_q;
    endcase
  end

  assign mag_ext = {1'b0, mag_q[16:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fp_q      <= '0;
      mag_q     <= '0;
      sh_q      <= '0;
      k_q       <= '0;
      fixed_out <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      nan       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) fp_q <= fp_in;
        end
        StClassify: begin
          mag_q <= {1'b1, fp_q[22:0]};
          sh_q  <= sh;
          k_q   <= 3'd4;
          if (is_nan) begin
            fixed_out <= '0;
            nan       <= 1'b1;
          end else if (is_inf) begin
            fixed_out <= fp_q[31] ? SAT_NEG : SAT_POS;
            ovf       <= 1'b1;
          end else if (is_zero || is_denorm) begin
            fixed_out <= '0;
            unf       <= is_denorm;
          end else if (too_small) begin
            fixed_out <= '0;
            unf       <= 1'b1;
          end else if (is_neg_two) begin
            fixed_out <= SAT_NEG;
          end else if (too_big) begin
            fixed_out <= fp_q[31] ? SAT_NEG : SAT_POS;
            ovf       <= 1'b1;
          end
        end
        StShift: begin
          mag_q <= mag_shift;
          k_q   <= k_q - 3'd1;
        end
        StNegate: begin
          fixed_out <= fp_q[31] ? -mag_ext : mag_ext;
        end
        StDone: begin
          if (out_ready) begin
            ovf <= 1'b0;
            unf <= 1'b0;
            nan <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_fixed_seq.sv
// Directed-vector bench for fp_to_fixed_seq: values, flags, latency, backpressure
// and asynchronous reset during the shift.
module tb_fp_to_fixed_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_in;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] fixed_out;
  logic        ovf, unf, nan;

  int checks = 0;
  int errors = 0;

  fp_to_fixed_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_in     (fp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fixed_out (fixed_out),
    .ovf       (ovf),
    .unf       (unf),
    .nan       (nan)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present fp at a falling edge; returns after the accept edge N plus half a cycle.
  task automatic launch(input logic [31:0] fp);
    in_valid = 1'b1;
    fp_in    = fp;
    check_eq("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    fp_in    = $urandom;
  endtask

  // Number of edges after N until out_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  // Latency 7 = out_valid during cycle N+8; latency 1 = during cycle N+2.
  task automatic convert(input string tag, input logic [31:0] fp, input logic [17:0] exp_fx,
                         input logic exp_ovf, input logic exp_unf, input logic exp_nan,
                         input int exp_lat);
    int lat;
    launch(fp);
    wait_valid(lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_fixed"}, 32'(fixed_out), 32'(exp_fx));
    check_eq({tag, "_flags"}, {29'd0, ovf, unf, nan}, {29'd0, exp_ovf, exp_unf, exp_nan});
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_post_hs"}, {28'd0, out_valid, ovf, unf, nan}, 32'd0);
    check_eq({tag, "_ready_again"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [17:0] held;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    fp_in     = '0;
    #23;
    check_eq("reset_outputs", {13'd0, in_ready, out_valid, ovf, unf, nan, fixed_out},
             {13'd0, 1'b1, 1'b0, 3'b000, 18'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    convert("one",      32'h3F80_0000, 18'h10000, 1'b0, 1'b0, 1'b0, 7);
    convert("m_half",   32'hBF00_0000, 18'h38000, 1'b0, 1'b0, 1'b0, 7);
    convert("lsb",      32'h3780_0000, 18'h00001, 1'b0, 1'b0, 1'b0, 7);
    convert("one_half", 32'h3FC0_0000, 18'h18000, 1'b0, 1'b0, 1'b0, 7);
    convert("trunc",    32'h3F80_0001, 18'h10000, 1'b0, 1'b0, 1'b0, 7);
    convert("max_pos",  32'h3FFF_FFFF, 18'h1FFFF, 1'b0, 1'b0, 1'b0, 7);
    convert("max_neg",  32'hBFFF_FFFF, 18'h20001, 1'b0, 1'b0, 1'b0, 7);
    convert("p_2_5",    32'h4020_0000, 18'h1FFFF, 1'b1, 1'b0, 1'b0, 1);
    convert("p_two",    32'h4000_0000, 18'h1FFFF, 1'b1, 1'b0, 1'b0, 1);
    convert("m_two",    32'hC000_0000, 18'h20000, 1'b0, 1'b0, 1'b0, 1);
    convert("m_inf",    32'hFF80_0000, 18'h20000, 1'b1, 1'b0, 1'b0, 1);
    convert("nan",      32'h7FC0_0000, 18'h00000, 1'b0, 1'b0, 1'b1, 1);
    convert("tiny",     32'h358637BD,  18'h00000, 1'b0, 1'b1, 1'b0, 1);
    convert("below",    32'h3700_0000, 18'h00000, 1'b0, 1'b1, 1'b0, 1);
    convert("denorm",   32'h0000_0001, 18'h00000, 1'b0, 1'b1, 1'b0, 1);
    convert("m_zero",   32'h8000_0000, 18'h00000, 1'b0, 1'b0, 1'b0, 1);

    // Backpressure: result held, new input ignored while busy.
    launch(32'h3FC0_0000);
    wait_valid(lat);
    check_eq("bp_lat", 32'(lat), 32'd7);
    held = fixed_out;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      fp_in    = 32'h4020_0000;
      @(posedge clk);
      @(negedge clk);
      check_eq("bp_hold", {12'd0, out_valid, in_ready, ovf, unf, nan, fixed_out},
               {12'd0, 1'b1, 1'b0, 3'b000, 18'h18000});
    end
    check_eq("bp_held_value", 32'(fixed_out), 32'(held));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("bp_release", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    convert("after_bp", 32'hBF00_0000, 18'h38000, 1'b0, 1'b0, 1'b0, 7);

    // Asynchronous reset while the shifter is mid-way.
    launch(32'h3F80_0000);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid", {12'd0, out_valid, in_ready, ovf, unf, nan, fixed_out},
             {12'd0, 1'b0, 1'b1, 3'b000, 18'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    convert("after_rst", 32'h3F80_0000, 18'h10000, 1'b0, 1'b0, 1'b0, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_to_fixed_seq.md
# fp_to_fixed_seq

Multi-cycle converter from an IEEE-754 single-precision value to the signed Q2.16 fixed-point format (18 bits) used by the CORDIC datapath. It sits on the operand-load path, so software can write float operands that the CORDIC core consumes as Q2.16. It is the inverse of the existing fixed-to-float output converter. Values are taken in and results are returned through valid/ready handshakes, with one conversion in flight at a time. The alignment shift is staged over five cycles to keep the logic area small.

## Interface
- Parameters: none. The format is fixed at Q2.16, and its constants live in the package.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fp_in holds a value to convert.
- in_ready  out  1  block can accept a value (high only in IDLE).
- fp_in  in  32  IEEE-754 single: {sign, exp[7:0], mant[22:0]}.
- out_valid  out  1  result and flags are valid. Held until out_ready.
- out_ready  in  1  consumer accepts the result.
- fixed_out  out  18  signed Q2.16 result. Registered, and holds its last value.
- ovf  out  1  result was saturated.
- unf  out  1  a nonzero input flushed to 0.
- nan  out  1  input was NaN.

## Operation
- States: IDLE, CLASSIFY, SHIFT (5 sub-steps, counter k=4..0), NEGATE, DONE.
- IDLE: in_ready=1. When in_valid is high, capture fp_in and go to CLASSIFY.
- CLASSIFY: set sig24={1,mant}, sh=134-exp.
  - NaN (exp=255, mant≠0): fixed_out=0, nan=1, go to DONE.
  - Inf (exp=255, mant=0): saturate, ovf=1, go to DONE.
  - Zero or denormal (exp=0): fixed_out=0. Set unf=1 if mant≠0. Go to DONE.
  - exp<111: fixed_out=0, unf=1, go to DONE.
  - exp≥128: saturate, ovf=1, go to DONE. Exception: exactly -2.0 (0xC0000000) gives 18'h20000 with ovf=0.
  - Otherwise (111≤exp≤127, so sh is 7..23): go to SHIFT.
- Saturation value: +131071 (18'h1FFFF) for positive sign, -131072 (18'h20000) for negative sign.
- SHIFT: on step k, mag = sh[k] ? mag>>(1<<k) : mag. Step order is 16, 8, 4, 2, 1, one step per cycle. Then go to NEGATE.
- Magnitude handling:
  - Magnitude is truncated toward zero. There is no rounding.
  - After the shift, mag fits in 17 bits.
  - NEGATE computes fixed_out = sign ? -mag : mag.
  - -0.0 gives 0 with no flags.
- DONE: out_valid=1. When out_ready is high, go to IDLE, drop out_valid, and clear the flags.

## Timing
- Let N be the accept edge (the rising edge with in_valid && in_ready).
- Normal path: out_valid rises at N+8. That is CLASSIFY N+1, SHIFT N+2..N+6, NEGATE N+7.
- Special path (NaN, Inf, zero, underflow, overflow): out_valid rises at N+2.
- out_valid, fixed_out and the flags stay stable while out_valid && !out_ready.
- in_ready is combinational from state, so it is low from N+1 until the cycle after the DONE handshake.
- Throughput: at most one conversion per 9 cycles.
- in_valid while busy is ignored. fp_in may change freely after N.
- Reset (asynchronous, any state, including mid-SHIFT):
  - state returns to IDLE.
  - out_valid=0; ovf=unf=nan=0; fixed_out=0.
  - in_ready=1 after reset, since state is IDLE.
- out_ready while out_valid=0 has no effect.

## Structure
- Package fp_to_fixed_pkg holds:
  - EXP_BIAS=127, FRAC_BITS=16, INT_BITS=2.
  - SHIFT_BASE=134, EXP_MIN=111, EXP_MAX=127.
  - SAT_POS=18'h1FFFF, SAT_NEG=18'h20000.
  - The state enum.
- One sub-module, fp_classify: combinational. It decodes fp_in into {is_nan, is_inf, is_zero, is_denorm, too_small, too_big, is_neg_two, sh[4:0]}.
- The FSM, shifter register and negation stay in the top module.

## Test plan
- 1.0 (0x3F800000) -> fixed_out=18'h10000, no flags, out_valid at N+8.
- -0.5 (0xBF000000) -> 18'h38000; 2^-16 (0x37800000) -> 18'h00001; 1.5 (0x3FC00000) -> 18'h18000.
- Saturation cases:
  - 2.5 (0x40200000) -> 18'h1FFFF, ovf=1, out_valid at N+2.
  - -2.0 (0xC0000000) -> 18'h20000, ovf=0.
  - -inf (0xFF800000) -> 18'h20000, ovf=1.
- NaN / underflow / zero cases:
  - NaN (0x7FC00000) -> 0, nan=1.
  - 1e-6 (0x358637BD) -> 0, unf=1.
  - Denormal 0x00000001 -> 0, unf=1.
  - -0.0 (0x80000000) -> 0, no flags.
- Backpressure: hold out_ready low 5 cycles after out_valid. Output and flags stay stable, in_ready stays 0, and a new in_valid is ignored. A release-cycle handshake gives in_ready=1 on the next cycle.
- Reset mid-operation: assert rst_n=0 during SHIFT (N+4). out_valid=0 and fixed_out=0 immediately. After release, in_ready=1, and the next conversion of 1.0 is correct.
